// File: rtl/axis_arb_pkg.sv
// Shared types and the rotating-priority search used by the AXI-Stream arbiters.
package axis_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit of req searching last+1, last+2, ... modulo n; returns last when req is empty.
  function automatic int rr_next(input logic [31:0] req, input int last, input int n);
    int idx;
    rr_next = last;
    for (int k = 32; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (req[idx[4:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle; USE_LIGHT_STREAM removes TLAST so every beat is its own packet.
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
`ifdef USE_LIGHT_STREAM
  modport m (output tvalid, tdata, tkeep, tid, tdest, tuser, input tready);
  modport s (input tvalid, tdata, tkeep, tid, tdest, tuser, output tready);
`else
  logic                    tlast;
  modport m (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport s (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after the previous owner.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] pick,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [31:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = IW'(rr_next(req_ext, int'(last), N));
    any            = |req;
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter; grant is held from first beat to TLAST.
// Optional ARB_WATCHDOG_EN releases a grant whose owner stays idle for TIMEOUT_CYCLES.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_INPUTS       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int DEST_WIDTH     = 4,
  parameter int USER_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  axis_if.s                           in [N_INPUTS],
  axis_if.m                           out,
  output logic [$clog2(N_INPUTS)-1:0] grant,
  output logic                        busy,
  output logic                        timeout
);
  localparam int GW = $clog2(N_INPUTS);
  localparam int KW = DATA_WIDTH / 8;

  logic [N_INPUTS-1:0]   req;
  logic [N_INPUTS-1:0]   src_ready;
  logic [DATA_WIDTH-1:0] src_data [N_INPUTS];
  logic [KW-1:0]         src_keep [N_INPUTS];
  logic [ID_WIDTH-1:0]   src_id   [N_INPUTS];
  logic [DEST_WIDTH-1:0] src_dest [N_INPUTS];
  logic [USER_WIDTH-1:0] src_user [N_INPUTS];
`ifndef USE_LIGHT_STREAM
  logic [N_INPUTS-1:0]   src_last;
`endif

  arb_state_t      state_q, state_d;
  logic [GW-1:0]   grant_d, last_q, last_d, pick;
  logic            any_req, beat_last, wd_fire;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_src
    assign req[i]         = in[i].tvalid;
    assign src_data[i]    = in[i].tdata;
    assign src_keep[i]    = in[i].tkeep;
    assign src_id[i]      = in[i].tid;
    assign src_dest[i]    = in[i].tdest;
    assign src_user[i]    = in[i].tuser;
    assign in[i].tready   = src_ready[i];
`ifndef USE_LIGHT_STREAM
    assign src_last[i]    = in[i].tlast;
`endif
  end

  rr_pick #(.N(N_INPUTS)) u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  assign busy      = (state_q == GRANT);
  assign out.tvalid = busy && req[grant];
  assign out.tdata  = src_data[grant];
  assign out.tkeep  = src_keep[grant];
  assign out.tid    = src_id[grant];
  assign out.tdest  = src_dest[grant];
  assign out.tuser  = src_user[grant];
`ifdef USE_LIGHT_STREAM
  assign beat_last  = busy && req[grant] && out.tready;
`else
  assign out.tlast  = src_last[grant];
  assign beat_last  = busy && req[grant] && out.tready && src_last[grant];
`endif

  always_comb begin
    src_ready = '0;
    if (busy) src_ready[grant] = out.tready;
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_q, wd_d;
  logic          timeout_q;

  // Counter is held at zero outside GRANT, which also clears it on entry.
  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (!busy || req[grant]) begin
      wd_d = '0;
    end else if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
      wd_d    = CW'(TIMEOUT_CYCLES);
      wd_fire = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= wd_fire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (beat_last || wd_fire) begin
          last_d  = grant;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Input 0 starts with top priority because the search begins after N_INPUTS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant   <= '0;
      last_q  <= GW'(N_INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      last_q  <= last_d;
    end
  end
endmodule
